// File: rtl/vga_frame_signature_pkg.sv
// Shared types and constants for the VGA frame signature monitor.
package vga_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } mon_state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  // Standard 640x480@60 timing
  localparam int VGA_H_ACT   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACT   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_TOTAL = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_frame_signature_if.sv
// Video sample, control and result signals of the frame signature monitor.
interface vga_frame_signature_if #(
  parameter int PIX_W = 24,
  parameter int CNT_W = 12
);
  logic             pix_en;
  logic             h_sync;
  logic             v_sync;
  logic [PIX_W-1:0] pix;
  logic             arm;
  logic             clear;
  logic             busy;
  logic             done;
  logic [31:0]      sig;
  logic [19:0]      pix_cnt;
  logic [CNT_W-1:0] h_len;
  logic [CNT_W-1:0] v_lines;
  logic             timing_err;
  logic [15:0]      frame_cnt;

  modport master (
    output pix_en, h_sync, v_sync, pix, arm, clear,
    input  busy, done, sig, pix_cnt, h_len, v_lines, timing_err, frame_cnt
  );

  modport slave (
    input  pix_en, h_sync, v_sync, pix, arm, clear,
    output busy, done, sig, pix_cnt, h_len, v_lines, timing_err, frame_cnt
  );
endinterface

// File: rtl/vga_frame_signature_crc32_word.sv
// Combinational CRC-32 update for one W-bit word, MSB first, no reflection.
module crc32_word
  import vga_mon_pkg::*;
#(
  parameter int W = 24
) (
  input  logic [31:0]  crc_in,
  input  logic [W-1:0] data,
  output logic [31:0]  crc_out
);

  logic [31:0] crc_w;

  // One polynomial division step per data bit, starting at the MSB
  always_comb begin
    crc_w = crc_in;
    for (int i = W - 1; i >= 0; i--) begin
      if (crc_w[31] ^ data[i]) begin
        crc_w = {crc_w[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        crc_w = {crc_w[30:0], 1'b0};
      end
    end
    crc_out = crc_w;
  end

endmodule

// File: rtl/vga_frame_signature.sv
// Monitor beside the VGA output: measures line/frame timing and reduces the
// active pixels of a frame to a CRC-32 signature.
//
//  state   | meaning
//  IDLE    | not capturing; waits for arm (auto re-arm when CONTINUOUS)
//  WAIT_VS | armed; waits for the vsync leading edge that opens a frame
//  CAPTURE | hashing active pixels and measuring lines until the next vsync edge
//  DONE    | one-clk result strobe; then IDLE, or straight back to CAPTURE
module vga_frame_signature
  import vga_mon_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int CH_W       = 8,
  parameter int H_ACT      = VGA_H_ACT,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACT      = VGA_V_ACT,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int SYNC_POL   = 0,
  parameter int CONTINUOUS = 0,
  parameter int CNT_W      = 12
) (
  input logic                  clk,
  input logic                  rst,
  vga_frame_signature_if.slave bus
);

  localparam int PIX_W = NUM_CH * CH_W;
  localparam logic             SYNC_LVL = (SYNC_POL != 0);
  localparam logic             CONT     = (CONTINUOUS != 0);
  localparam logic [CNT_W-1:0] H_TOT_C  = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_TOT_C  = CNT_W'(V_ACT + V_FP + V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] X_LO     = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] X_HI     = CNT_W'(H_SYNC + H_BP + H_ACT);
  localparam logic [CNT_W-1:0] Y_LO     = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] Y_HI     = CNT_W'(V_SYNC + V_BP + V_ACT);

  mon_state_e       state_q, state_d;
  logic             hs_prev_q, hs_prev_d;
  logic             vs_prev_q, vs_prev_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [31:0]      crc_q, crc_d;
  logic [19:0]      pcnt_q, pcnt_d;
  logic             line_err_q, line_err_d;
  logic             first_hs_q, first_hs_d;
  logic [31:0]      sig_q, sig_d;
  logic [19:0]      pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] h_len_q, h_len_d;
  logic [CNT_W-1:0] v_lines_q, v_lines_d;
  logic             timing_err_q, timing_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             hs_act, vs_act, hs_e, vs_e;
  logic [CNT_W-1:0] x_next, y_next, line_len, v_lines_new;
  logic             in_frame, start, close, active, hashing, measure, line_err_upd;
  logic [31:0]      crc_next;

  assign hs_act = (bus.h_sync == SYNC_LVL);
  assign vs_act = (bus.v_sync == SYNC_LVL);
  assign hs_e   = bus.pix_en && hs_act && !hs_prev_q;
  assign vs_e   = bus.pix_en && vs_act && !vs_prev_q;

  // x_next/y_next are the coordinates of the sample being taken now;
  // x_q/y_q still describe the previous sample (used for line/frame lengths)
  assign x_next      = hs_e ? '0 : ((&x_q) ? x_q : x_q + 1'b1);
  assign y_next      = vs_e ? '0 : ((hs_e && !(&y_q)) ? y_q + 1'b1 : y_q);
  assign line_len    = x_q + 1'b1;
  assign v_lines_new = y_q + 1'b1;

  // In continuous mode the DONE clk already belongs to the next frame
  assign in_frame = (state_q == CAPTURE) || (CONT && (state_q == DONE));
  assign start    = !bus.clear && (state_q == WAIT_VS) && vs_e;
  assign close    = !bus.clear && (state_q == CAPTURE) && vs_e;
  assign active   = (x_next >= X_LO) && (x_next < X_HI) && (y_next >= Y_LO) && (y_next < Y_HI);
  assign hashing  = in_frame && bus.pix_en && !vs_e && active;
  assign measure  = in_frame && hs_e && !first_hs_q;
  assign line_err_upd = line_err_q | (measure && (line_len != H_TOT_C));

  crc32_word #(.W(PIX_W)) u_crc (
    .crc_in  (crc_q),
    .data    (bus.pix),
    .crc_out (crc_next)
  );

  // Next-state decode; clear overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.arm || CONT) state_d = WAIT_VS;
      WAIT_VS: if (vs_e) state_d = CAPTURE;
      CAPTURE: if (vs_e) state_d = DONE;
      DONE:    state_d = CONT ? CAPTURE : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  // Sample counters, CRC accumulation and result latching
  always_comb begin
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    x_d          = x_q;
    y_d          = y_q;
    crc_d        = crc_q;
    pcnt_d       = pcnt_q;
    line_err_d   = line_err_q;
    first_hs_d   = first_hs_q;
    sig_d        = sig_q;
    pix_cnt_d    = pix_cnt_q;
    h_len_d      = h_len_q;
    v_lines_d    = v_lines_q;
    timing_err_d = timing_err_q;
    frame_cnt_d  = frame_cnt_q;

    if (bus.pix_en) begin
      hs_prev_d = hs_act;
      vs_prev_d = vs_act;
      x_d       = x_next;
      y_d       = y_next;
    end
    if (hashing) begin
      crc_d  = crc_next;
      pcnt_d = pcnt_q + 1'b1;
    end
    if (measure) begin
      h_len_d    = line_len;
      line_err_d = line_err_upd;
    end
    if (in_frame && hs_e) first_hs_d = 1'b0;
    // The closing edge still measures the last line before results are taken
    if (close) begin
      sig_d        = crc_q;
      pix_cnt_d    = pcnt_q;
      v_lines_d    = v_lines_new;
      timing_err_d = line_err_upd | (v_lines_new != V_TOT_C);
      frame_cnt_d  = frame_cnt_q + 1'b1;
    end
    // An hsync edge on the opening sample is the frame's first and is not a line end
    if (start || (close && CONT)) begin
      crc_d      = CRC32_INIT;
      pcnt_d     = '0;
      line_err_d = 1'b0;
      first_hs_d = !hs_e;
    end
    if (bus.clear) frame_cnt_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      crc_q        <= CRC32_INIT;
      pcnt_q       <= '0;
      line_err_q   <= 1'b0;
      first_hs_q   <= 1'b1;
      sig_q        <= '0;
      pix_cnt_q    <= '0;
      h_len_q      <= '0;
      v_lines_q    <= '0;
      timing_err_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      x_q          <= x_d;
      y_q          <= y_d;
      crc_q        <= crc_d;
      pcnt_q       <= pcnt_d;
      line_err_q   <= line_err_d;
      first_hs_q   <= first_hs_d;
      sig_q        <= sig_d;
      pix_cnt_q    <= pix_cnt_d;
      h_len_q      <= h_len_d;
      v_lines_q    <= v_lines_d;
      timing_err_q <= timing_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.busy       = (state_q == WAIT_VS) || (state_q == CAPTURE);
  assign bus.done       = (state_q == DONE);
  assign bus.sig        = sig_q;
  assign bus.pix_cnt    = pix_cnt_q;
  assign bus.h_len      = h_len_q;
  assign bus.v_lines    = v_lines_q;
  assign bus.timing_err = timing_err_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed bench for the frame signature monitor on a scaled-down raster
// (16 samples x 11 lines, 8x6 active) so that whole frames stay short.
module tb_vga_frame_signature;

  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACT = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;   // 16
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;   // 11
  localparam int PIX_W = 24;
  localparam int CNT_W = 12;

  logic clk;
  logic rst;

  vga_frame_signature_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus0 ();
  vga_frame_signature_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus1 ();

  vga_frame_signature #(
    .NUM_CH(3), .CH_W(8), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .CONTINUOUS(0), .CNT_W(CNT_W)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  vga_frame_signature #(
    .NUM_CH(3), .CH_W(8), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(0), .CONTINUOUS(1), .CNT_W(CNT_W)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done0_cnt = 0;
  int          done1_cnt = 0;
  logic [31:0] sig1_log [8];
  logic        chk_clear_next = 1'b0;
  logic [31:0] exp_zero;
  logic [31:0] exp_grad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC: xor the word into the top of the register, then shift it out
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 24; i++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [23:0] pix_of(input int pat, input int x);
    logic [7:0] xb;
    xb = 8'(x);
    return (pat == 1) ? {xb, xb, xb} : 24'h0;
  endfunction

  function automatic logic [31:0] frame_sig(input int pat);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int y = V_SYNC + V_BP; y < V_SYNC + V_BP + V_ACT; y++)
      for (int x = H_SYNC + H_BP; x < H_SYNC + H_BP + H_ACT; x++)
        c = crc_model(c, pix_of(pat, x));
    return c;
  endfunction

  // Count done strobes; log the continuous monitor's signatures
  always @(negedge clk) begin
    if (bus0.done === 1'b1) done0_cnt++;
    if (bus1.done === 1'b1) begin
      if (done1_cnt < 8) sig1_log[done1_cnt] = bus1.sig;
      done1_cnt++;
    end
  end

  task automatic set_in(input logic pe, input logic hs, input logic vs, input logic [23:0] p,
                        input logic a, input logic c);
    bus0.pix_en = pe; bus0.h_sync = hs; bus0.v_sync = vs; bus0.pix = p; bus0.arm = a; bus0.clear = c;
    bus1.pix_en = pe; bus1.h_sync = hs; bus1.v_sync = vs; bus1.pix = p; bus1.arm = a; bus1.clear = c;
  endtask

  task automatic settle();
    repeat (3) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    end
    #2;
  endtask

  task automatic arm_pulse();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b1, 1'b0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},    32'(bus0.busy), 32'd0);
    chk({tag, "_done"},    32'(bus0.done), 32'd0);
    chk({tag, "_sig"},     bus0.sig, 32'd0);
    chk({tag, "_pixcnt"},  32'(bus0.pix_cnt), 32'd0);
    chk({tag, "_hlen"},    32'(bus0.h_len), 32'd0);
    chk({tag, "_vlines"},  32'(bus0.v_lines), 32'd0);
    chk({tag, "_terr"},    32'(bus0.timing_err), 32'd0);
    chk({tag, "_fcnt"},    32'(bus0.frame_cnt), 32'd0);
  endtask

  // One raster frame; ev_kind at (ev_y, x=0): 1 = arm, 2 = clear, 3 = rst low
  task automatic drive_frame(input int pat, input int gap_pct, input int short_y,
                             input int ev_y, input int ev_kind);
    for (int y = 0; y < V_TOT; y++) begin
      int len;
      len = (y == short_y) ? H_TOT - 1 : H_TOT;
      for (int x = 0; x < len; x++) begin
        logic ev;
        ev = (y == ev_y) && (x == 0);
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
          repeat ($urandom_range(2, 1)) begin
            @(negedge clk);
            set_in(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), 1'b0, 1'b0);
          end
        end
        @(negedge clk);
        if (chk_clear_next) begin
          chk("t6_clear_busy", 32'(bus0.busy), 32'd0);
          chk("t6_clear_done", 32'(bus0.done), 32'd0);
          chk_clear_next = 1'b0;
        end
        set_in(1'b1, !(x < H_SYNC), !(y < V_SYNC), pix_of(pat, x),
               ev && (ev_kind == 1), ev && (ev_kind == 2));
        chk_clear_next = ev && (ev_kind == 2);
        if (ev && ev_kind == 3) begin
          rst = 1'b0;
          #1;
          check_reset_outputs("t6_rst");
        end
      end
    end
  endtask

  initial begin
    exp_zero = frame_sig(0);
    exp_grad = frame_sig(1);
    rst = 1'b0;
    set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);

    // 1: reset held with random inputs
    repeat (20) begin
      @(negedge clk);
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 1'($urandom), 1'($urandom));
    end
    #1;
    check_reset_outputs("t1");
    chk("t1_busy1", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // 2: ideal raster, zero pixels, single-shot capture
    arm_pulse();
    drive_frame(0, 0, -1, -1, 0);
    drive_frame(0, 0, -1, -1, 0);
    settle();
    chk("t2_done_cnt", 32'(done0_cnt), 32'd1);
    chk("t2_vlines",   32'(bus0.v_lines), 32'(V_TOT));
    chk("t2_hlen",     32'(bus0.h_len), 32'(H_TOT));
    chk("t2_pixcnt",   32'(bus0.pix_cnt), 32'(H_ACT * V_ACT));
    chk("t2_terr",     32'(bus0.timing_err), 32'd0);
    chk("t2_sig",      bus0.sig, exp_zero);
    chk("t2_fcnt",     32'(bus0.frame_cnt), 32'd1);
    chk("t2_busy",     32'(bus0.busy), 32'd0);

    // 3: one active line one sample short (front porch sample dropped)
    arm_pulse();
    drive_frame(0, 0, 4, -1, 0);
    drive_frame(0, 0, -1, -1, 0);
    settle();
    chk("t3_done_cnt", 32'(done0_cnt), 32'd2);
    chk("t3_terr",     32'(bus0.timing_err), 32'd1);
    chk("t3_sig",      bus0.sig, exp_zero);
    chk("t3_vlines",   32'(bus0.v_lines), 32'(V_TOT));
    chk("t3_fcnt",     32'(bus0.frame_cnt), 32'd2);

    // 4: continuous mode, gradient pixels, four vsync edges
    rst_pulse();
    done0_cnt = 0;
    done1_cnt = 0;
    for (int f = 0; f < 4; f++) drive_frame(1, 0, -1, -1, 0);
    settle();
    chk("t4_done_cnt", 32'(done1_cnt), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_sig%0d", i), sig1_log[i], exp_grad);
    chk("t4_fcnt",     32'(bus1.frame_cnt), 32'd3);
    chk("t4_terr",     32'(bus1.timing_err), 32'd0);
    chk("t4_pixcnt",   32'(bus1.pix_cnt), 32'(H_ACT * V_ACT));
    chk("t4_vlines",   32'(bus1.v_lines), 32'(V_TOT));
    chk("t4_idle_dut0", 32'(done0_cnt), 32'd0);

    // 5: same pixels with random pix_en gaps
    rst_pulse();
    done0_cnt = 0;
    done1_cnt = 0;
    for (int f = 0; f < 4; f++) drive_frame(1, 30, -1, -1, 0);
    settle();
    chk("t5_done_cnt", 32'(done1_cnt), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("t5_sig%0d", i), sig1_log[i], exp_grad);
    chk("t5_fcnt",     32'(bus1.frame_cnt), 32'd3);
    chk("t5_terr",     32'(bus1.timing_err), 32'd0);

    // 6a: arm during CAPTURE is ignored; the frame still completes
    done0_cnt = 0;
    arm_pulse();
    drive_frame(1, 0, -1, 3, 1);
    drive_frame(1, 0, -1, -1, 0);
    settle();
    chk("t6a_done_cnt", 32'(done0_cnt), 32'd1);
    chk("t6a_sig",      bus0.sig, exp_grad);
    chk("t6a_fcnt",     32'(bus0.frame_cnt), 32'd1);

    // 6b: clear mid-frame aborts without a result
    arm_pulse();
    drive_frame(1, 0, -1, 5, 2);
    drive_frame(1, 0, -1, -1, 0);
    settle();
    chk("t6b_done_cnt", 32'(done0_cnt), 32'd1);
    chk("t6b_fcnt",     32'(bus0.frame_cnt), 32'd0);
    chk("t6b_sig_held", bus0.sig, exp_grad);
    chk("t6b_busy",     32'(bus0.busy), 32'd0);

    // 6c: reset mid-frame, then no capture without a new arm
    arm_pulse();
    drive_frame(1, 0, -1, 8, 3);
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 24'h0, 1'b0, 1'b0);
    rst = 1'b1;
    drive_frame(1, 0, -1, -1, 0);
    drive_frame(1, 0, -1, -1, 0);
    settle();
    chk("t6c_done_cnt", 32'(done0_cnt), 32'd1);
    chk("t6c_busy",     32'(bus0.busy), 32'd0);
    chk("t6c_sig",      bus0.sig, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
